// File: rtl/clken_nco_gen.sv
// Multi-channel phase-accumulator NCO: fractional-rate clock enables and square waves
// from one reference clock, with phase-continuous retuning and a settle-based lock flag.
module clken_nco_gen #(
    parameter int                      NUM_CH        = 2,
    parameter int                      ACC_W         = 32,
    parameter int                      CH_W          = 1,
    parameter int                      SETTLE_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT      = {32'd1229922393, 32'd617769198}
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [NUM_CH-1:0]   clken,
    output logic [NUM_CH-1:0]   clk_sq,
    output logic                locked
);

    localparam logic [1:0]      ST_IDLE    = 2'd0;
    localparam logic [1:0]      ST_PEND    = 2'd1;
    localparam logic [1:0]      ST_DONE    = 2'd2;
    localparam logic [15:0]     SETTLE_MAX = 16'(SETTLE_CYCLES);
    localparam logic [CH_W:0]   NUM_CH_W   = (CH_W + 1)'(NUM_CH);

    logic [1:0]        state_q, state_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [ACC_W-1:0]  pend_inc_q, pend_inc_d;
    logic [15:0]       settle_q, settle_d;
    logic              locked_q;
    logic [NUM_CH-1:0] inc_wr;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] inc_q;
        logic             clken_q;
        logic             sq_q;
        logic [ACC_W:0]   sum;

        assign sum = {1'b0, acc_q} + {1'b0, inc_q};

        // New rate lands on a wrap so the following add already uses it; a channel
        // that cannot wrap (disabled or frozen) takes it straight away.
        assign inc_wr[gi] = (state_q == ST_PEND) && (pend_ch_q == CH_W'(gi)) &&
                            (!ch_en[gi] || (inc_q == '0) || sum[ACC_W]);

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q   <= '0;
                inc_q   <= INC_INIT[gi*ACC_W +: ACC_W];
                clken_q <= 1'b0;
                sq_q    <= 1'b0;
            end else begin
                if (ch_en[gi]) begin
                    acc_q   <= sum[ACC_W-1:0];
                    clken_q <= sum[ACC_W];
                    sq_q    <= sq_q ^ sum[ACC_W];
                end else begin
                    acc_q   <= '0;
                    clken_q <= 1'b0;
                    sq_q    <= 1'b0;
                end
                if (inc_wr[gi]) begin
                    inc_q <= pend_inc_q;
                end
            end
        end

        assign clken[gi]  = clken_q;
        assign clk_sq[gi] = sq_q;
    end

    always_comb begin
        state_d     = state_q;
        cfg_ready_d = cfg_ready_q;
        pend_ch_d   = pend_ch_q;
        pend_inc_d  = pend_inc_q;
        case (state_q)
            ST_IDLE: begin
                cfg_ready_d = 1'b1;
                if (cfg_valid && cfg_ready_q) begin
                    cfg_ready_d = 1'b0;
                    // Out-of-range targets are swallowed: ready drops for one cycle only
                    if ({1'b0, cfg_ch} < NUM_CH_W) begin
                        state_d    = ST_PEND;
                        pend_ch_d  = cfg_ch;
                        pend_inc_d = cfg_inc;
                    end
                end
            end
            ST_PEND: begin
                if (|inc_wr) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                cfg_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        settle_d = settle_q;
        if (|inc_wr) begin
            settle_d = '0;
        end else if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + 16'd1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b0;
            pend_ch_q   <= '0;
            pend_inc_q  <= '0;
            settle_q    <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            pend_ch_q   <= pend_ch_d;
            pend_inc_q  <= pend_inc_d;
            settle_q    <= settle_d;
            locked_q    <= (settle_d == SETTLE_MAX);
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_clken_nco_gen.sv
// Bench for clken_nco_gen: directed scenarios plus randomized traffic, every cycle
// compared against a phase-total reference model.
module tb_clken_nco_gen;

    localparam int AW = 8;
    localparam int NC = 2;
    localparam int ST = 4;

    logic          refclk;
    logic          rst_n;
    logic [NC-1:0] ch_en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [AW-1:0] cfg_inc;
    logic [NC-1:0] clken;
    logic [NC-1:0] clk_sq;
    logic          locked;

    clken_nco_gen #(
        .NUM_CH(NC), .ACC_W(AW), .CH_W(2), .SETTLE_CYCLES(ST), .INC_INIT(16'h0040)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .ch_en(ch_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
        .clken(clken), .clk_sq(clk_sq), .locked(locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference model: unbounded running phase per channel; a pulse is a new multiple of 2^AW
    int     init_inc [NC] = '{64, 0};
    longint m_ph     [NC];
    int     m_inc    [NC];
    bit     m_sq     [NC];
    int     m_since;
    bit     m_ready, m_rel, m_pend;
    int     m_pch, m_pinc;
    logic [6:0] exp_vec;

    function automatic bit wraps(input int ch);
        return ((m_ph[ch] + m_inc[ch]) >> AW) != (m_ph[ch] >> AW);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_ph[c] = 0; m_inc[c] = init_inc[c]; m_sq[c] = 0;
        end
        m_since = 0; m_ready = 0; m_rel = 1; m_pend = 0; m_pch = 0; m_pinc = 0;
    endtask

    task automatic model_step();
        bit wrote, accept;
        logic [NC-1:0] ck;
        wrote  = 0;
        ck     = '0;
        accept = cfg_valid && m_ready;
        if (m_pend && (!ch_en[m_pch] || m_inc[m_pch] == 0 || wraps(m_pch))) wrote = 1;
        for (int c = 0; c < NC; c++) begin
            if (ch_en[c]) begin
                ck[c] = wraps(c);
                m_ph[c] = m_ph[c] + m_inc[c];
                m_sq[c] = m_sq[c] ^ ck[c];
            end else begin
                m_ph[c] = 0; m_sq[c] = 0;
            end
        end
        if (wrote) m_inc[m_pch] = m_pinc;
        if (m_rel) begin m_ready = 1; m_rel = 0; end
        if (accept) begin
            m_ready = 0;
            if (int'(cfg_ch) >= NC) m_rel = 1;
            else begin m_pend = 1; m_pch = int'(cfg_ch); m_pinc = int'(cfg_inc); end
        end else if (wrote) begin
            m_pend = 0; m_rel = 1;
        end
        if (wrote) m_since = 0;
        else if (m_since < 1000) m_since++;
        exp_vec = {m_ready, (m_since >= ST), m_sq[1], m_sq[0], ck};
    endtask

    // Measurements taken from observed outputs, compared against constants by the tests
    int cyc;
    int last_p [NC], first_p [NC], pcnt [NC], last_iv [NC];
    int min_iv, max_iv, rdy_low, unlock_cnt, lock_cyc;

    task automatic clr_stats();
        for (int c = 0; c < NC; c++) begin first_p[c] = -1; pcnt[c] = 0; end
        min_iv = 9999; max_iv = 0; rdy_low = 0; unlock_cnt = 0; lock_cyc = -1;
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        model_step();
        check("cycle", {25'd0, cfg_ready, locked, clk_sq, clken}, {25'd0, exp_vec});
        cyc++;
        for (int c = 0; c < NC; c++) begin
            if (clken[c]) begin
                if (last_p[c] >= 0) begin
                    last_iv[c] = cyc - last_p[c];
                    if (c == 0 && last_iv[c] < min_iv) min_iv = last_iv[c];
                    if (c == 0 && last_iv[c] > max_iv) max_iv = last_iv[c];
                end
                last_p[c] = cyc;
                pcnt[c]++;
                if (first_p[c] < 0) first_p[c] = cyc;
            end
        end
        if (!cfg_ready) rdy_low++;
        if (!locked) unlock_cnt++;
        if (locked && lock_cyc < 0) lock_cyc = cyc;
    endtask

    task automatic do_reset(input logic [NC-1:0] en);
        rst_n = 1'b0; cfg_valid = 1'b0; ch_en = en;
        #1;
        check("reset_state", {28'd0, cfg_ready, locked, clk_sq[0], clken[0]}, 32'd0);
        model_reset();
        repeat (2) @(posedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
        cyc = 0;
        for (int c = 0; c < NC; c++) begin last_p[c] = -1; last_iv[c] = 0; end
        clr_stats();
    endtask

    task automatic send_cfg(input logic [1:0] ch, input logic [AW-1:0] inc);
        int n;
        n = 0;
        cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = inc;
        while (cfg_ready !== 1'b1 && n < 100) begin step(); n++; end
        if (n >= 100) check("cfg_ready_timeout", 32'd0, 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cyc, n;
        rst_n = 1'b0; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;

        // 1: reset rates, first pulse and lock at cycle 4
        do_reset(2'b01);
        repeat (12) step();
        check("p1_first_pulse", first_p[0], 4);
        check("p1_lock_cycle", lock_cyc, 4);
        check("p1_ch0_pulses", pcnt[0], 3);
        check("p1_ch1_pulses", pcnt[1], 0);

        // 2: inc 96 gives 3 pulses per 8 cycles
        send_cfg(2'd0, 8'd96);
        repeat (8) step();
        clr_stats();
        repeat (800) step();
        check("p2_pulse_count", pcnt[0], 300);
        check("p2_min_interval", min_iv, 2);
        check("p2_max_interval", max_iv, 3);

        // 3: retune 64 -> 128 mid-stream
        do_reset(2'b01);
        repeat (10) step();
        clr_stats();
        send_cfg(2'd0, 8'd128);
        repeat (20) step();
        check("p3_min_interval", min_iv, 2);
        check("p3_max_interval", max_iv, 4);
        check("p3_final_interval", last_iv[0], 2);
        check("p3_unlocked_cycles", unlock_cnt, 4);

        // 4: retune a disabled channel, then re-enable
        ch_en = 2'b00;
        repeat (3) step();
        clr_stats();
        send_cfg(2'd0, 8'd32);
        repeat (4) step();
        check("p4_ready_low", rdy_low, 2);
        ch_en = 2'b01;
        en_cyc = cyc;
        n = 0;
        while (first_p[0] < 0 && n < 40) begin step(); n++; end
        check("p4_reenable_delay", first_p[0] - en_cyc, 8);

        // 5: frozen ch1 takes a new rate at once; out-of-range target is discarded
        ch_en = 2'b11;
        repeat (8) step();
        clr_stats();
        send_cfg(2'd1, 8'd16);
        repeat (40) step();
        check("p5_ready_low", rdy_low, 2);
        check("p5_ch1_interval", last_iv[1], 16);
        repeat (8) step();
        clr_stats();
        send_cfg(2'd3, 8'hAA);
        repeat (4) step();
        check("p5_bad_ch_ready_low", rdy_low, 1);
        check("p5_bad_ch_unlocked", unlock_cnt, 0);

        // 6: reset while a retune is pending
        repeat (2) step();
        send_cfg(2'd0, 8'd200);
        #2;
        rst_n = 1'b0;
        #1;
        check("p6_async_clken", {30'd0, clken}, 32'd0);
        check("p6_async_clk_sq", {30'd0, clk_sq}, 32'd0);
        check("p6_async_locked", {31'd0, locked}, 32'd0);
        do_reset(2'b11);
        repeat (20) step();
        check("p6_first_pulse", first_p[0], 4);
        check("p6_ch1_pulses", pcnt[1], 0);

        // Randomized traffic against the model
        do_reset(2'b11);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 31) == 0) ch_en[$urandom_range(0, 1)] = ~ch_en[$urandom_range(0, 1)];
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       cfg_inc = '0;
                1:       cfg_inc = 8'($urandom_range(128, 255));
                default: cfg_inc = 8'($urandom_range(1, 127));
            endcase
            step();
        end
        cfg_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
